// File: rtl/gen_seq_pkg.sv
// Shared flag bit positions and FSM encoding for the stream sequence generators.
// Pure declarations: no logic, no latency, no backpressure.
package gen_seq_pkg;

  localparam int MF_AGAIN = 3;
  localparam int MF_FIRST = 2;
  localparam int MF_LAST  = 1;
  localparam int MF_VLD   = 0;

  localparam int SF_ABT = 1;
  localparam int SF_BSY = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_axis_cnt.sv
// One count dimension: config snapshot on load, then step or rewind; value is registered.
// at_end is combinational from the registered value; the parent stalls by withholding step/rewind.
module seq_axis_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         rewind,
  input  logic [W-1:0] cfg_ini,
  input  logic [W-1:0] cfg_inc,
  input  logic [W-1:0] cfg_max,
  output logic [W-1:0] val,
  output logic         at_end
);

  logic [W-1:0] ini_q, ini_d;
  logic [W-1:0] inc_q, inc_d;
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] val_q, val_d;
  logic [W:0]   sum;

  always_comb begin
    ini_d = ini_q;
    inc_d = inc_q;
    max_d = max_q;
    val_d = val_q;
    if (load) begin
      ini_d = cfg_ini;
      inc_d = cfg_inc;
      max_d = cfg_max;
      val_d = cfg_ini;
    end else if (step) begin
      val_d = val_q + inc_q;
    end else if (rewind) begin
      val_d = ini_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ini_q <= '0;
      inc_q <= '0;
      max_q <= '0;
      val_q <= '0;
    end else begin
      ini_q <= ini_d;
      inc_q <= inc_d;
      max_q <= max_d;
      val_q <= val_d;
    end
  end

  // One extra bit so a wrapping step still reads as past the limit.
  always_comb begin
    sum    = {1'b0, val_q} + {1'b0, inc_q};
    at_end = (inc_q == '0) || (sum > {1'b0, max_q});
  end

  assign val = val_q;

endmodule

// File: rtl/gen_seq2d.sv
// 2-D inner/outer count sequence started by an upstream trigger; first beat 1 cycle after trigger.
// Holds while downstream is busy; abort forces idle next cycle; triggers only taken when cu_bsy=0.
module gen_seq2d
  import gen_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cfg_ini0,
  input  logic [W-1:0] cfg_inc0,
  input  logic [W-1:0] cfg_max0,
  input  logic [W-1:0] cfg_ini1,
  input  logic [W-1:0] cfg_inc1,
  input  logic [W-1:0] cfg_max1,
  input  logic [W-1:0] uc_d0,
  input  logic [3:0]   uc_mflags,
  output logic [1:0]   cu_sflags,
  output logic [W-1:0] cd_d0,
  output logic [W-1:0] cd_d1,
  output logic         cd_eol,
  output logic [3:0]   cd_mflags,
  input  logic [1:0]   dc_sflags
);

  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   run, trig, acc, dc_abt, dc_bsy, cu_bsy, take;
  logic   inner_end, outer_end, seq_last;
  logic   step_i, rewind_i;
  logic   unused_ok;

  assign unused_ok = ^{uc_d0, uc_mflags[MF_LAST]};

  assign dc_abt   = dc_sflags[SF_ABT];
  assign dc_bsy   = dc_sflags[SF_BSY];
  assign run      = (state_q == ST_RUN);
  assign trig     = uc_mflags[MF_VLD] & uc_mflags[MF_FIRST] & ~uc_mflags[MF_AGAIN];
  assign acc      = run & ~dc_bsy;
  assign seq_last = run & inner_end & outer_end;
  assign cu_bsy   = dc_abt | (run & ~(acc & seq_last));
  assign take     = trig & ~cu_bsy;
  assign step_i   = acc & ~dc_abt & ~inner_end;
  assign rewind_i = acc & ~dc_abt & inner_end & ~outer_end;

  seq_axis_cnt #(.W(W)) u_inner (
    .clk     (clk),
    .rst     (rst),
    .load    (take),
    .step    (step_i),
    .rewind  (rewind_i),
    .cfg_ini (cfg_ini0),
    .cfg_inc (cfg_inc0),
    .cfg_max (cfg_max0),
    .val     (cd_d0),
    .at_end  (inner_end)
  );

  seq_axis_cnt #(.W(W)) u_outer (
    .clk     (clk),
    .rst     (rst),
    .load    (take),
    .step    (rewind_i),
    .rewind  (1'b0),
    .cfg_ini (cfg_ini1),
    .cfg_inc (cfg_inc1),
    .cfg_max (cfg_max1),
    .val     (cd_d1),
    .at_end  (outer_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Abort outranks both a restart trigger and acceptance of the final beat.
  always_comb begin
    state_d = state_q;
    if (dc_abt) begin
      state_d = ST_IDLE;
    end else if (take) begin
      state_d = ST_RUN;
    end else if (acc && seq_last) begin
      state_d = ST_IDLE;
    end
    first_d = first_q;
    if (take) begin
      first_d = 1'b1;
    end else if (acc) begin
      first_d = 1'b0;
    end
  end

  always_comb begin
    cd_mflags           = '0;
    cd_mflags[MF_AGAIN] = dc_bsy;
    cd_mflags[MF_FIRST] = run & first_q;
    cd_mflags[MF_LAST]  = seq_last;
    cd_mflags[MF_VLD]   = run;
    cd_eol              = run & inner_end;
    cu_sflags           = '0;
    cu_sflags[SF_ABT]   = dc_abt;
    cu_sflags[SF_BSY]   = cu_bsy;
  end

endmodule

// File: tb/tb_gen_seq2d.sv
// Directed table-driven bench for gen_seq2d at W=8; each vector drives one cycle and checks it.
module tb_gen_seq2d;
  import gen_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cfg_ini0, cfg_inc0, cfg_max0, cfg_ini1, cfg_inc1, cfg_max1;
  logic [W-1:0] uc_d0;
  logic [3:0]   uc_mflags;
  logic [1:0]   cu_sflags;
  logic [W-1:0] cd_d0, cd_d1;
  logic         cd_eol;
  logic [3:0]   cd_mflags;
  logic [1:0]   dc_sflags;

  always #5 clk = ~clk;

  gen_seq2d #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_ini0  (cfg_ini0),
    .cfg_inc0  (cfg_inc0),
    .cfg_max0  (cfg_max0),
    .cfg_ini1  (cfg_ini1),
    .cfg_inc1  (cfg_inc1),
    .cfg_max1  (cfg_max1),
    .uc_d0     (uc_d0),
    .uc_mflags (uc_mflags),
    .cu_sflags (cu_sflags),
    .cd_d0     (cd_d0),
    .cd_d1     (cd_d1),
    .cd_eol    (cd_eol),
    .cd_mflags (cd_mflags),
    .dc_sflags (dc_sflags)
  );

  typedef struct {
    logic         trig, bsy, abt;
    logic         vld;
    logic [W-1:0] d0, d1;
    logic         first, eol, last, cub;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  int    vn    = 0;
  string tag;
  vec_t  tbl[$];

  logic [W-1:0] e0[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  logic [W-1:0] e1[9] = '{10, 10, 10, 15, 15, 15, 20, 20, 20};

  function automatic vec_t mk(input logic trig, bsy, abt, vld,
                              input logic [W-1:0] d0, d1,
                              input logic first, eol, last, cub);
    vec_t v;
    v.trig = trig; v.bsy = bsy; v.abt = abt; v.vld = vld;
    v.d0 = d0; v.d1 = d1;
    v.first = first; v.eol = eol; v.last = last; v.cub = cub;
    return v;
  endfunction

  task automatic set_cfg(input logic [W-1:0] a, b, c, d, e, f);
    cfg_ini0 = a; cfg_inc0 = b; cfg_max0 = c;
    cfg_ini1 = d; cfg_inc1 = e; cfg_max1 = f;
  endtask

  // Counts are don't-care while idle, so they are masked to zero on both sides.
  task automatic cyc(input vec_t v);
    logic [22:0] act, exp_v;
    @(negedge clk);
    uc_mflags = {1'b0, v.trig, 1'b0, v.trig};
    dc_sflags = {v.abt, v.bsy};
    #2;
    act   = {cd_mflags[MF_VLD], v.vld ? cd_d0 : 8'd0, v.vld ? cd_d1 : 8'd0,
             cd_mflags[MF_FIRST], cd_eol, cd_mflags[MF_LAST],
             cu_sflags[SF_BSY], cd_mflags[MF_AGAIN], cu_sflags[SF_ABT]};
    exp_v = {v.vld, v.vld ? v.d0 : 8'd0, v.vld ? v.d1 : 8'd0,
             v.first, v.eol, v.last, v.cub, v.bsy, v.abt};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s vec %0d: got %h want %h (vld,d0,d1,first,eol,last,cu_bsy,again,cu_abt)",
               tag, vn, act, exp_v);
    end
    vn++;
  endtask

  task automatic run_tbl(input string name);
    tag = name;
    vn  = 0;
    for (int k = 0; k < tbl.size(); k++) cyc(tbl[k]);
    tbl.delete();
  endtask

  initial begin
    rst       = 1'b1;
    uc_d0     = '0;
    uc_mflags = '0;
    dc_sflags = '0;
    set_cfg(0, 1, 2, 10, 5, 20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    total++;
    if ({cd_mflags, cd_eol, cd_d0, cd_d1} !== 21'd0) begin
      bad++;
      $display("FAIL reset: got mflags=%b eol=%b d0=%0d d1=%0d want all 0",
               cd_mflags, cd_eol, cd_d0, cd_d1);
    end

    // Plain 3x3 walk.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(0, 0, 0, 1, e0[k], e1[k], k == 0, (k % 3) == 2, k == 8, k != 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("walk3x3");

    // Busy every other cycle: each beat shown twice, accepted on the second.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(0, 1, 0, 1, e0[k], e1[k], k == 0, (k % 3) == 2, k == 8, 1));
      tbl.push_back(mk(0, 0, 0, 1, e0[k], e1[k], k == 0, (k % 3) == 2, k == 8, k != 8));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("bsy_toggle");

    set_cfg(250, 4, 255, 0, 1, 1);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 250, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 254, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 250, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 254, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("overflow");

    set_cfg(7, 0, 9, 0, 1, 1);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("inc0_zero");

    set_cfg(5, 1, 3, 4, 2, 3);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 4, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("ini_gt_max");

    // Restart on the last beat; cfg is changed mid-run to prove the snapshot.
    tag = "restart";
    vn  = 0;
    set_cfg(0, 1, 1, 0, 0, 0);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    set_cfg(3, 1, 3, 7, 0, 0);
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0));
    cyc(mk(0, 0, 0, 1, 3, 7, 1, 1, 1, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Abort at beat 4 with a simultaneous trigger, then a clean restart.
    tag = "abort";
    vn  = 0;
    set_cfg(0, 1, 2, 10, 5, 20);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      cyc(mk(0, 0, 0, 1, e0[k], e1[k], k == 0, k == 2, 0, 1));
    cyc(mk(1, 0, 1, 1, 0, 15, 0, 0, 0, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 0, 10, 1, 0, 0, 1));
    cyc(mk(0, 0, 0, 1, 1, 10, 0, 0, 0, 1));
    cyc(mk(0, 0, 1, 1, 2, 10, 0, 1, 0, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset mid-sequence wins over a simultaneous trigger.
    tag = "rst_mid";
    vn  = 0;
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 1, 0, 10, 1, 0, 0, 1));
    @(negedge clk);
    rst       = 1'b1;
    uc_mflags = 4'b0101;
    @(negedge clk);
    rst       = 1'b0;
    uc_mflags = 4'b0000;
    #2;
    total++;
    if ({cd_mflags[MF_VLD], cd_d0, cd_d1} !== 17'd0) begin
      bad++;
      $display("FAIL rst_mid: got vld=%b d0=%0d d1=%0d want 0 0 0",
               cd_mflags[MF_VLD], cd_d0, cd_d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
